// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart transmitter; drains one byte per load, pacing on uart_tx_busy.
// Define UART_TX_FIFO_OVF_EN to add the sticky overflow flag (ovf / ovf_clr).
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [7:0]        uart_din,
    output logic              uart_wr_en,
    input  logic              uart_tx_busy,
`ifdef UART_TX_FIFO_OVF_EN
    input  logic              ovf_clr,
    output logic              ovf,
`endif
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full
);

    localparam int LVL_W = ADDR_W + 1;
    localparam int CNT_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [LVL_W-1:0]  LEVEL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LEVEL_ONE  = LVL_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  busy_cnt;
    logic              push;
    logic              pop;

    // Full is judged on the pre-edge level, so a pop on the same edge never frees room for a push.
    assign empty    = (level == '0);
    assign full     = (level == LEVEL_FULL);
    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign pop      = (state == IDLE) && !empty && !uart_tx_busy;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    // A load that never sees busy rise is treated as sent after BUSY_TIMEOUT cycles; no retry.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            uart_din   <= 8'h00;
            uart_wr_en <= 1'b0;
            busy_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        uart_din   <= mem[rd_ptr];
                        rd_ptr     <= rd_ptr + PTR_ONE;
                        uart_wr_en <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    uart_wr_en <= 1'b0;
                    busy_cnt   <= '0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (uart_tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (busy_cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        busy_cnt <= busy_cnt + CNT_ONE;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    uart_wr_en <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    // Set has priority over clear so an overflow on the clearing edge is not lost.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf <= 1'b0;
        end else if (wr_valid && full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model plus a behavioural uart busy model.
// Builds with or without UART_TX_FIFO_OVF_EN.
module tb_uart_tx_fifo;

    localparam int DEPTH        = 16;
    localparam int ADDR_W       = 4;
    localparam int BUSY_TIMEOUT = 4;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [7:0]      wr_data;
    logic            wr_valid;
    logic            wr_ready;
    logic [7:0]      uart_din;
    logic            uart_wr_en;
    logic            uart_tx_busy;
    logic [ADDR_W:0] level;
    logic            empty;
    logic            full;
`ifdef UART_TX_FIFO_OVF_EN
    logic            ovf_clr;
    logic            ovf;
    logic            ovf_m;
`endif

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] model_q[$];
    int         uart_mode;
    int         busy_len;
    int         busy_left;
    int         cycle;
    int         pulse_count;
    int         last_pulse_cycle;
    int         pulse_gap;
    int         accepted;
    int         next_byte;
    int         budget;
    logic       prev_wr_en;
    logic [7:0] last_emit;

    uart_tx_fifo #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .uart_din     (uart_din),
        .uart_wr_en   (uart_wr_en),
        .uart_tx_busy (uart_tx_busy),
`ifdef UART_TX_FIFO_OVF_EN
        .ovf_clr      (ovf_clr),
        .ovf          (ovf),
`endif
        .level        (level),
        .empty        (empty),
        .full         (full)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock edge: drive inputs, advance, then compare against the queue model.
    // uart_mode 0 = busy follows each load for busy_len cycles, 1 = busy held high, 2 = busy held low.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic clr);
        int   pre;
        logic acc;
        wr_valid = v;
        wr_data  = d;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr = clr;
`endif
        case (uart_mode)
            1:       uart_tx_busy = 1'b1;
            2:       uart_tx_busy = 1'b0;
            default: uart_tx_busy = (busy_left > 0);
        endcase
        pre = model_q.size();
        acc = v && (pre < DEPTH);
        @(posedge CLK);
        #1;
        cycle++;
        if (uart_wr_en === 1'b1) begin
            checkOutput("wr_en_spacing", prev_wr_en, 0);
            checkOutput("pop_nonempty", (pre != 0), 1);
            if (pre != 0) begin
                last_emit = model_q.pop_front();
                checkOutput("uart_din", uart_din, last_emit);
            end
            pulse_gap        = cycle - last_pulse_cycle;
            last_pulse_cycle = cycle;
            pulse_count++;
            busy_left = busy_len;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        if (acc) begin
            model_q.push_back(d);
            accepted++;
        end
`ifdef UART_TX_FIFO_OVF_EN
        if (v && pre == DEPTH) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        checkOutput("ovf", ovf, ovf_m);
`else
        if (clr) busy_left = busy_left;
`endif
        checkOutput("level", level, model_q.size());
        checkOutput("empty", empty, (model_q.size() == 0));
        checkOutput("full", full, (model_q.size() == DEPTH));
        checkOutput("wr_ready", wr_ready, (model_q.size() != DEPTH));
        prev_wr_en = uart_wr_en;
    endtask

    task automatic drainFifo(input int limit);
        int n;
        n = 0;
        while (model_q.size() != 0 && n < limit) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            n++;
        end
        checkOutput("drain_done", model_q.size(), 0);
        repeat (BUSY_TIMEOUT + busy_len + 4) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_level"}, level, 0);
        checkOutput({tag, "_empty"}, empty, 1);
        checkOutput({tag, "_full"}, full, 0);
        checkOutput({tag, "_wr_ready"}, wr_ready, 1);
        checkOutput({tag, "_wr_en"}, uart_wr_en, 0);
        checkOutput({tag, "_din"}, uart_din, 8'h00);
`ifdef UART_TX_FIFO_OVF_EN
        checkOutput({tag, "_ovf"}, ovf, 0);
`endif
    endtask

    initial begin
        RST_N            = 1'b0;
        wr_valid         = 1'b0;
        wr_data          = 8'h00;
        uart_tx_busy     = 1'b0;
        uart_mode        = 0;
        busy_len         = 3;
        busy_left        = 0;
        cycle            = 0;
        pulse_count      = 0;
        last_pulse_cycle = 0;
        pulse_gap        = 0;
        accepted         = 0;
        next_byte        = 0;
        budget           = 0;
        prev_wr_en       = 1'b0;
        last_emit        = 8'h00;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr = 1'b0;
        ovf_m   = 1'b0;
`endif
        #12;
        checkReset("reset");
        RST_N = 1'b1;

        // Single byte: load strobe appears after the second edge
        applyStimulus(1'b1, 8'hA5, 1'b0);
        checkOutput("single_no_early", uart_wr_en, 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("single_latency", uart_wr_en, 1);
        checkOutput("single_din", uart_din, 8'hA5);
        drainFifo(50);
        checkOutput("single_level", level, 0);
        checkOutput("single_din_hold", uart_din, 8'hA5);

        // Fill with busy held: seventeenth byte is dropped
        uart_mode   = 1;
        pulse_count = 0;
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        checkOutput("fill_level", level, DEPTH);
        checkOutput("fill_full", full, 1);
        checkOutput("fill_wr_ready", wr_ready, 0);
`ifdef UART_TX_FIFO_OVF_EN
        checkOutput("fill_ovf", ovf, 1);
`endif
        uart_mode = 0;
        busy_left = 0;
        drainFifo(400);
        checkOutput("fill_emitted", pulse_count, 16);
        checkOutput("fill_last", last_emit, 8'h0F);
`ifdef UART_TX_FIFO_OVF_EN
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("ovf_clear", ovf, 0);
`endif

        // Simultaneous push and pop at level 3 and at level 16
        uart_mode = 1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h30 + 8'(i), 1'b0);
        uart_mode = 2;
        applyStimulus(1'b1, 8'h33, 1'b0);
        checkOutput("simul3_pop", uart_wr_en, 1);
        checkOutput("simul3_level", level, 3);
        uart_mode = 1;
        for (int i = 0; i < 13; i++) applyStimulus(1'b1, 8'h40 + 8'(i), 1'b0);
        checkOutput("simul16_full", full, 1);
        uart_mode = 2;
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b1);
        checkOutput("simul16_pop", uart_wr_en, 1);
        checkOutput("simul16_level", level, 15);
`ifdef UART_TX_FIFO_OVF_EN
        checkOutput("ovf_set_wins", ovf, 1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("ovf_clear2", ovf, 0);
`endif
        uart_mode = 0;
        busy_left = 0;
        drainFifo(400);

        // Busy never rises: each load times out
        uart_mode   = 2;
        pulse_count = 0;
        applyStimulus(1'b1, 8'h5A, 1'b0);
        applyStimulus(1'b1, 8'hC3, 1'b0);
        repeat (20) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("timeout_count", pulse_count, 2);
        checkOutput("timeout_gap", pulse_gap - 1, BUSY_TIMEOUT + 1);
        checkOutput("timeout_last", last_emit, 8'hC3);

        // Reset while the uart is still shifting
        uart_mode = 1;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h70 + 8'(i), 1'b0);
        uart_mode = 2;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("midop_load", uart_wr_en, 1);
        uart_mode = 1;
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        checkReset("midop_reset");
        model_q.delete();
        prev_wr_en = 1'b0;
        busy_left  = 0;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_m = 1'b0;
`endif
        #1;
        RST_N       = 1'b1;
        pulse_count = 0;
        repeat (6) applyStimulus(1'b0, 8'h00, 1'b0);
        uart_mode = 2;
        repeat (6) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("midop_no_load", pulse_count, 0);

        // Randomized traffic with varied busy lengths (0 exercises the timeout path)
        uart_mode   = 0;
        busy_left   = 0;
        pulse_count = 0;
        accepted    = 0;
        for (int i = 0; i < 400; i++) begin
            busy_len = $urandom_range(0, 5);
            applyStimulus(($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 15) == 0));
        end
        busy_len = 5;
        drainFifo(400);
        checkOutput("random_balance", pulse_count, accepted);

        // Loopback stream 8'h00..8'hFF, writing whenever there is room
        busy_len    = 8;
        busy_left   = 0;
        pulse_count = 0;
        next_byte   = 0;
        budget      = 0;
        while (next_byte < 256 && budget < 6000) begin
            if (model_q.size() < DEPTH) begin
                applyStimulus(1'b1, 8'(next_byte), 1'b0);
                next_byte++;
            end else begin
                applyStimulus(1'b0, 8'h00, 1'b0);
            end
            budget++;
        end
        checkOutput("loop_feed", next_byte, 256);
        drainFifo(400);
        checkOutput("loop_count", pulse_count, 256);
        checkOutput("loop_last", last_emit, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
